mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle for mem_arbiter: fetch port, data port, shared memory port and grant counters.
// master = requesters plus memory model, slave = the arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_rw;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_EN;
  logic              mem_RW;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [31:0]       stat_i_grants;
  logic [31:0]       stat_d_grants;

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_rw, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_EN, mem_RW, mem_addr, mem_wdata,
    output mem_rdata,
    input  stat_i_grants, stat_d_grants
  );

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_rw, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_EN, mem_RW, mem_addr, mem_wdata,
    input  mem_rdata,
    output stat_i_grants, stat_d_grants
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one single-port memory, data priority with fetch anti-starvation.
// Optional per-port grant counters are built when MEM_ARB_STATS_EN is defined.
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  state_e            state_q, state_d;
  logic              owner_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        starve_q, starve_d;

  logic              arb_cycle;
  logic              grant_i;
  logic              grant_d;
  logic              any_grant;

  // Arbitration is combinational and suppressed while reset is asserted.
  always_comb begin
    arb_cycle = !rst && ((state_q == StIdle) || (state_q == StResp));
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    if (arb_cycle) begin
      if (bus.i_req && (starve_q == StarveMax)) begin
        grant_i = 1'b1;
      end else if (bus.d_req) begin
        grant_d = 1'b1;
      end else if (bus.i_req) begin
        grant_i = 1'b1;
      end
    end
    any_grant = grant_i | grant_d;
  end

  always_comb begin
    starve_d = starve_q;
    if (arb_cycle) begin
      if (grant_i || !bus.i_req) begin
        starve_d = 4'd0;
      end else if (grant_d && (starve_q != StarveMax)) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   state_d = any_grant ? StAccess : StIdle;
      StAccess: state_d = StResp;
      StResp:   state_d = any_grant ? StAccess : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Transaction registers captured on the grant edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
      if (any_grant) begin
        owner_q <= grant_d;
        rw_q    <= grant_d & bus.d_rw;
        addr_q  <= grant_d ? bus.d_addr : bus.i_addr;
        wdata_q <= grant_d ? bus.d_wdata : '0;
      end
    end
  end

  // Output logic; everything is forced quiet during a reset cycle so an aborted access leaks nothing.
  always_comb begin
    bus.i_gnt     = grant_i;
    bus.d_gnt     = grant_d;
    bus.mem_EN    = 1'b0;
    bus.mem_RW    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.i_rvalid  = 1'b0;
    bus.i_rdata   = '0;
    bus.d_rvalid  = 1'b0;
    bus.d_rdata   = '0;
    if (!rst) begin
      unique case (state_q)
        StAccess: begin
          bus.mem_EN    = 1'b1;
          bus.mem_RW    = rw_q;
          bus.mem_addr  = addr_q;
          bus.mem_wdata = wdata_q;
        end
        StResp: begin
          if (owner_q) begin
            bus.d_rvalid = 1'b1;
            bus.d_rdata  = rw_q ? '0 : bus.mem_rdata;
          end else begin
            bus.i_rvalid = 1'b1;
            bus.i_rdata  = bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_i_q;
  logic [31:0] stat_d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_i_q <= '0;
      stat_d_q <= '0;
    end else begin
      if (grant_i && (stat_i_q != 32'hFFFF_FFFF)) begin
        stat_i_q <= stat_i_q + 32'd1;
      end
      if (grant_d && (stat_d_q != 32'hFFFF_FFFF)) begin
        stat_d_q <= stat_d_q + 32'd1;
      end
    end
  end

  assign bus.stat_i_grants = stat_i_q;
  assign bus.stat_d_grants = stat_d_q;
`else
  assign bus.stat_i_grants = '0;
  assign bus.stat_d_grants = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a memory model plus a grant-driven scoreboard of expected
// memory accesses and responses, checked with immediate assertions.
module tb_mem_arbiter;

`ifdef MEM_ARB_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    bit          port;
    logic [31:0] data;
    int          due;
  } rsp_t;

  typedef struct {
    bit          rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          due;
  } acc_t;

  rsp_t        rq[$];
  acc_t        mq[$];
  logic [31:0] mem_arr[256];
  logic [31:0] shadow[256];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model: read data registered one cycle after mem_EN.
  always @(posedge clk) begin
    if (bus.mem_EN === 1'b1) begin
      if (bus.mem_RW) mem_arr[bus.mem_addr[7:0]] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem_arr[bus.mem_addr[7:0]];
    end
  end

  // Monitor: grants push expectations, memory accesses and responses pop them.
  always @(negedge clk) begin
    check("gnt_onehot", 64'(bus.i_gnt & bus.d_gnt), 64'd0);
    check("rvalid_onehot", 64'(bus.i_rvalid & bus.d_rvalid), 64'd0);
    if (!bus.i_rvalid) check("i_rdata_idle", 64'(bus.i_rdata), 64'd0);
    if (!bus.d_rvalid) check("d_rdata_idle", 64'(bus.d_rdata), 64'd0);
    if (bus.i_gnt) begin
      rq.push_back('{port: 1'b0, data: shadow[bus.i_addr[7:0]], due: cyc + 2});
      mq.push_back('{rw: 1'b0, addr: bus.i_addr, wdata: 32'd0, due: cyc + 1});
    end
    if (bus.d_gnt) begin
      rq.push_back('{port: 1'b1, data: bus.d_rw ? 32'd0 : shadow[bus.d_addr[7:0]], due: cyc + 2});
      mq.push_back('{rw: bus.d_rw, addr: bus.d_addr, wdata: bus.d_wdata, due: cyc + 1});
      if (bus.d_rw) shadow[bus.d_addr[7:0]] = bus.d_wdata;
    end
    if (bus.mem_EN) begin
      check("mem_en_expected", 64'(mq.size() > 0), 64'd1);
      if (mq.size() > 0) begin
        acc_t a;
        a = mq.pop_front();
        check("mem_en_cycle", 64'(cyc), 64'(a.due));
        check("mem_rw", 64'(bus.mem_RW), 64'(a.rw));
        check("mem_addr", 64'(bus.mem_addr), 64'(a.addr));
        check("mem_wdata", 64'(bus.mem_wdata), 64'(a.wdata));
      end
    end else begin
      check("mem_idle_addr", 64'({bus.mem_RW, bus.mem_addr, bus.mem_wdata}), 64'd0);
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        check("mem_en_seen", 64'(bus.mem_EN), 64'd1);
        void'(mq.pop_front());
      end
    end
    if (bus.i_rvalid || bus.d_rvalid) begin
      check("rvalid_expected", 64'(rq.size() > 0), 64'd1);
      if (rq.size() > 0) begin
        rsp_t r;
        r = rq.pop_front();
        check("rsp_cycle", 64'(cyc), 64'(r.due));
        check("rsp_port", 64'(bus.d_rvalid), 64'(r.port));
        check("rsp_data", 64'(bus.d_rvalid ? bus.d_rdata : bus.i_rdata), 64'(r.data));
      end
    end else if (rq.size() > 0 && rq[0].due <= cyc) begin
      check("rvalid_seen", 64'(bus.i_rvalid | bus.d_rvalid), 64'd1);
      void'(rq.pop_front());
    end
  end

  task automatic fetch(input logic [31:0] a);
    bit got = 1'b0;
    bus.i_req  = 1'b1;
    bus.i_addr = a;
    for (int k = 0; k < 20 && !got; k++) begin
      #1 got = bus.i_gnt;
      @(posedge clk);
      #1;
    end
    check("i_gnt_wait", 64'(got), 64'd1);
    bus.i_req = 1'b0;
  endtask

  task automatic data(input bit rw, input logic [31:0] a, input logic [31:0] wd);
    bit got = 1'b0;
    bus.d_req   = 1'b1;
    bus.d_rw    = rw;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    for (int k = 0; k < 20 && !got; k++) begin
      #1 got = bus.d_gnt;
      @(posedge clk);
      #1;
    end
    check("d_gnt_wait", 64'(got), 64'd1);
    bus.d_req = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && (rq.size() + mq.size()) > 0; k++) begin
      @(posedge clk);
      #1;
    end
    check("drain", 64'(rq.size() + mq.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gcount;
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = {24'hA5C3E1, 8'(i)};
      shadow[i]  = {24'hA5C3E1, 8'(i)};
    end
    mem_arr[8'h10] = 32'hDEAD_BEEF;
    shadow[8'h10]  = 32'hDEAD_BEEF;
    bus.mem_rdata = '0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_rw = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    rst = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_en", 64'(bus.mem_EN), 64'd0);
    check("rst_rvalid", 64'({bus.i_rvalid, bus.d_rvalid}), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_gnt", 64'({bus.i_gnt, bus.d_gnt}), 64'd0);
    check("rst_stat_i", 64'(bus.stat_i_grants), 64'd0);
    check("rst_stat_d", 64'(bus.stat_d_grants), 64'd0);

    // Single fetch, data write, readback, then back-to-back fetches.
    fetch(32'h10);
    drain();
    data(1'b1, 32'h20, 32'h1234);
    drain();
    data(1'b0, 32'h20, 32'h0);
    drain();
    fetch(32'h14);
    fetch(32'h18);
    drain();
    check("stat_i_3", 64'(bus.stat_i_grants), StatsOn ? 64'd3 : 64'd0);
    check("stat_d_2", 64'(bus.stat_d_grants), StatsOn ? 64'd2 : 64'd0);

    // Simultaneous requests from IDLE: data first, fetch in the RESP cycle.
    bus.i_req = 1'b1; bus.i_addr = 32'h24;
    bus.d_req = 1'b1; bus.d_rw = 1'b0; bus.d_addr = 32'h28; bus.d_wdata = '0;
    #1;
    check("sim_first_d", 64'({bus.i_gnt, bus.d_gnt}), 64'b01);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    #1;
    check("sim_access_none", 64'({bus.i_gnt, bus.d_gnt}), 64'b00);
    @(posedge clk); #2;
    check("sim_resp_i", 64'({bus.i_gnt, bus.d_gnt}), 64'b10);
    @(posedge clk); #1;
    bus.i_req = 1'b0;
    drain();

    // Both held: four data grants then one fetch grant, repeating.
    bus.i_req = 1'b1; bus.i_addr = 32'h44;
    bus.d_req = 1'b1; bus.d_rw = 1'b0; bus.d_addr = 32'h40; bus.d_wdata = '0;
    gcount = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.i_gnt || bus.d_gnt) begin
        check("starve_pattern", 64'({bus.i_gnt, bus.d_gnt}),
              (gcount % 5 == 4) ? 64'b10 : 64'b01);
        gcount++;
      end
      @(posedge clk); #1;
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    check("starve_grants", 64'(gcount), 64'd10);
    drain();

    // Reset during the ACCESS cycle of a fetch aborts it without a response.
    bus.i_req = 1'b1; bus.i_addr = 32'h30;
    #1;
    check("abort_gnt", 64'(bus.i_gnt), 64'd1);
    @(posedge clk); #1;
    bus.i_req = 1'b0;
    rst = 1'b1;
    rq.delete();
    mq.delete();
    #1;
    check("abort_rst_mem_en", 64'(bus.mem_EN), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_idle_mem_en", 64'(bus.mem_EN), 64'd0);
    check("abort_idle_rvalid", 64'({bus.i_rvalid, bus.d_rvalid}), 64'd0);
    check("abort_stat_i", 64'(bus.stat_i_grants), 64'd0);
    @(posedge clk); #1;
    check("abort_no_rvalid", 64'({bus.i_rvalid, bus.d_rvalid}), 64'd0);
    check("abort_no_mem_en", 64'(bus.mem_EN), 64'd0);
    fetch(32'h10);
    drain();
    check("post_abort_stat_i", 64'(bus.stat_i_grants), StatsOn ? 64'd1 : 64'd0);
    check("post_abort_stat_d", 64'(bus.stat_d_grants), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
